// File: rtl/alt_ddrx_refresh_timer.sv
// rtl/alt_ddrx_refresh_timer.sv - periodic auto-refresh scheduler with owed-refresh accounting
module alt_ddrx_refresh_timer #(
    parameter int MEM_IF_TREFI     = 1950,
    parameter int INIT_DELAY       = 64,
    parameter int MAX_PENDING      = 8,
    parameter int URGENT_THRESHOLD = 6,
    parameter int CNT_WIDTH        = 16
) (
    input  logic       ctl_clk,
    input  logic       ctl_reset_n,
    input  logic       ctl_cal_success,
    input  logic       local_refresh_req,
    input  logic       refresh_ack,
    output logic       refresh_req,
    output logic       refresh_urgent,
    output logic [3:0] refresh_pending,
    output logic       refresh_overflow,
    output logic       timer_active
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INIT   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TREFI_RELOAD = CNT_WIDTH'(MEM_IF_TREFI - 1);
    localparam logic [CNT_WIDTH-1:0] INIT_RELOAD  = CNT_WIDTH'((INIT_DELAY > 0) ? INIT_DELAY - 1 : 0);
    localparam logic [4:0]           MAX_P        = 5'(MAX_PENDING);
    localparam logic [3:0]           URGENT_P     = 4'(URGENT_THRESHOLD);

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [3:0]           pend_nxt;
    logic                 ovf_nxt;
    logic                 tick;
    logic [4:0]           sum;

    // Next-state, interval counter and owed-refresh arithmetic with saturation
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = refresh_pending;
        ovf_nxt   = refresh_overflow;
        tick      = 1'b0;
        sum       = 5'd0;
        case (state)
            S_IDLE: begin
                cnt_nxt  = '0;
                pend_nxt = 4'd0;
                if (ctl_cal_success) begin
                    if (INIT_DELAY == 0) begin
                        state_nxt = S_ACTIVE;
                        cnt_nxt   = TREFI_RELOAD;
                    end else begin
                        state_nxt = S_INIT;
                        cnt_nxt   = INIT_RELOAD;
                    end
                end
            end
            S_INIT: begin
                if (!ctl_cal_success) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    pend_nxt  = 4'd0;
                end else if (cnt == '0) begin
                    state_nxt = S_ACTIVE;
                    cnt_nxt   = TREFI_RELOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!ctl_cal_success) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    pend_nxt  = 4'd0;
                end else begin
                    // Reload on the tick edge itself so the period is exactly MEM_IF_TREFI
                    tick    = (cnt == '0);
                    cnt_nxt = tick ? TREFI_RELOAD : cnt - 1'b1;
                    sum     = {1'b0, refresh_pending} + 5'(tick) + 5'(local_refresh_req)
                              - 5'(refresh_ack && (refresh_pending != 4'd0));
                    if (sum > MAX_P) begin
                        pend_nxt = MAX_P[3:0];
                        ovf_nxt  = 1'b1;
                    end else begin
                        pend_nxt = sum[3:0];
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                pend_nxt  = 4'd0;
            end
        endcase
    end

    // State, counter and registered outputs, all derived from the next-state values
    always_ff @(posedge ctl_clk) begin
        if (!ctl_reset_n) begin
            state            <= S_IDLE;
            cnt              <= '0;
            refresh_pending  <= 4'd0;
            refresh_overflow <= 1'b0;
            refresh_req      <= 1'b0;
            refresh_urgent   <= 1'b0;
            timer_active     <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            refresh_pending  <= pend_nxt;
            refresh_overflow <= ovf_nxt;
            refresh_req      <= (pend_nxt != 4'd0);
            refresh_urgent   <= (pend_nxt >= URGENT_P);
            timer_active     <= (state_nxt == S_ACTIVE);
        end
    end

endmodule

// File: tb/tb_alt_ddrx_refresh_timer.sv
// tb/tb_alt_ddrx_refresh_timer.sv - self-checking bench for alt_ddrx_refresh_timer
module tb_alt_ddrx_refresh_timer;

    localparam int TREFI = 16;
    localparam int INITD = 4;
    localparam int MAXP  = 8;
    localparam int URG   = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cal = 1'b0;
    logic       loc = 1'b0;
    logic       ack = 1'b0;
    logic       req, urgent, ovf, active;
    logic [3:0] pending;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alt_ddrx_refresh_timer #(
        .MEM_IF_TREFI(TREFI), .INIT_DELAY(INITD), .MAX_PENDING(MAXP),
        .URGENT_THRESHOLD(URG), .CNT_WIDTH(16)
    ) dut (
        .ctl_clk(clk), .ctl_reset_n(rst_n), .ctl_cal_success(cal),
        .local_refresh_req(loc), .refresh_ack(ack),
        .refresh_req(req), .refresh_urgent(urgent), .refresh_pending(pending),
        .refresh_overflow(ovf), .timer_active(active)
    );

    // Reference model: time-based view of a calibration session
    int edge_n = 0;
    bit m_sess = 0;
    int m_start = 0;
    int m_pend = 0;
    bit m_ovf = 0;
    bit m_act = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit c, input bit l, input bit a);
        int k, s, tk;
        if (!r) begin
            m_sess = 0; m_pend = 0; m_ovf = 0;
        end else if (!m_sess) begin
            if (c) begin m_sess = 1; m_start = edge_n; end
        end else if (!c) begin
            m_sess = 0; m_pend = 0;
        end else begin
            k = edge_n - m_start;
            if (k > INITD) begin
                tk = (((k - INITD) % TREFI) == 0) ? 1 : 0;
                s = m_pend + tk + int'(l) - ((a && m_pend != 0) ? 1 : 0);
                if (s > MAXP) begin m_pend = MAXP; m_ovf = 1; end
                else m_pend = s;
            end
        end
        m_act = m_sess && ((edge_n - m_start) >= INITD);
    endtask

    task automatic step(input bit r, input bit c, input bit l, input bit a);
        rst_n = r; cal = c; loc = l; ack = a;
        @(posedge clk);
        #1;
        model_edge(r, c, l, a);
        check("pending", int'(pending), m_pend);
        check("req", int'(req), int'(m_pend != 0));
        check("urgent", int'(urgent), int'(m_pend >= URG));
        check("overflow", int'(ovf), int'(m_ovf));
        check("active", int'(active), int'(m_act));
        edge_n++;
    endtask

    typedef struct {
        bit r, c, l, a;
        int n;
        int p;
        bit e_req, e_urg, e_ovf, e_act;
    } vec_t;

    vec_t tbl[$];

    initial begin
        bit rc;
        int ack_div;

        tbl.push_back('{0,0,0,0,  1, 0, 0,0,0,0});
        tbl.push_back('{1,0,0,0,100, 0, 0,0,0,0});
        tbl.push_back('{1,1,0,0,  4, 0, 0,0,0,0});
        tbl.push_back('{1,1,0,0,  1, 0, 0,0,0,1});
        tbl.push_back('{1,1,0,0, 15, 0, 0,0,0,1});
        tbl.push_back('{1,1,0,0,  1, 1, 1,0,0,1});
        tbl.push_back('{1,1,0,0, 16, 2, 1,0,0,1});
        tbl.push_back('{1,1,0,0, 48, 5, 1,0,0,1});
        tbl.push_back('{1,1,0,0, 16, 6, 1,1,0,1});
        tbl.push_back('{1,1,0,0, 32, 8, 1,1,0,1});
        tbl.push_back('{1,1,0,0, 16, 8, 1,1,1,1});
        tbl.push_back('{1,1,0,1,  8, 0, 0,0,1,1});
        tbl.push_back('{1,1,1,0,  3, 3, 1,0,1,1});
        tbl.push_back('{1,1,0,0,  4, 3, 1,0,1,1});
        tbl.push_back('{1,1,0,1,  1, 3, 1,0,1,1});
        tbl.push_back('{1,1,0,0, 15, 3, 1,0,1,1});
        tbl.push_back('{1,1,1,1,  1, 4, 1,0,1,1});
        tbl.push_back('{1,1,0,1,  4, 0, 0,0,1,1});
        tbl.push_back('{1,1,0,1,  2, 0, 0,0,1,1});
        tbl.push_back('{1,1,1,0,  5, 5, 1,0,1,1});
        tbl.push_back('{1,0,0,0,  1, 0, 0,0,1,0});
        tbl.push_back('{1,0,1,0,  3, 0, 0,0,1,0});
        tbl.push_back('{1,1,0,0,  4, 0, 0,0,1,0});
        tbl.push_back('{1,1,0,0,  1, 0, 0,0,1,1});
        tbl.push_back('{1,1,1,0,  9, 8, 1,1,1,1});
        tbl.push_back('{0,1,0,0,  1, 0, 0,0,0,0});
        tbl.push_back('{1,0,0,0,  2, 0, 0,0,0,0});

        for (int i = 0; i < tbl.size(); i++) begin
            for (int j = 0; j < tbl[i].n; j++)
                step(tbl[i].r, tbl[i].c, tbl[i].l, tbl[i].a);
            check($sformatf("row%0d_pending", i), int'(pending), tbl[i].p);
            check($sformatf("row%0d_req", i), int'(req), int'(tbl[i].e_req));
            check($sformatf("row%0d_urgent", i), int'(urgent), int'(tbl[i].e_urg));
            check($sformatf("row%0d_overflow", i), int'(ovf), int'(tbl[i].e_ovf));
            check($sformatf("row%0d_active", i), int'(active), int'(tbl[i].e_act));
        end

        // Randomized sessions: calibration drops, resets, local requests, acks at varying rates
        rc = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            ack_div = (i < 2000) ? 12 : 4;
            if ($urandom_range(0, 249) == 0) rc = ~rc;
            step(($urandom_range(0, 399) != 0), rc,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, ack_div - 1) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
